// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StArb,
      StLoad,
      StWaitBusy,
      StWaitDone,
      StGap
   } sched_state_e;

   localparam int unsigned NumReqDefault     = 2;
   localparam int unsigned WdogCyclesDefault = 16384;
   localparam int unsigned ClockDiv          = 868;
   localparam int unsigned IdW               = 2;

   // Round-robin successor of a requester index, wrapping at n.
   function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id, input int unsigned n);
      logic [IdW-1:0] res;
      if (int'(id) + 1 >= int'(n)) res = '0;
      else res = id + IdW'(1);
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick starting at ptr_i; with lock_i only ptr_i is eligible.
module rr_arbiter
   import uart_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ = NumReqDefault
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IdW-1:0]     ptr_i,
   input  logic               lock_i,
   output logic [IdW-1:0]     winner_o,
   output logic               any_valid_o
);

   always_comb begin
      winner_o    = ptr_i;
      any_valid_o = 1'b0;
      if (lock_i) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IdW'(i) == ptr_i && valid_i[i]) any_valid_o = 1'b1;
         end
      end else begin
         // Walk offsets from farthest to nearest so the nearest valid one wins.
         for (int unsigned k = NUM_REQ; k > 0; k--) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               if (valid_i[i] && ((int'(ptr_i) + int'(k) - 1) % int'(NUM_REQ)) == int'(i)) begin
                  winner_o    = IdW'(i);
                  any_valid_o = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between NUM_REQ byte requesters with frame locking.
// Optional transfer watchdog enabled by defining UART_SCHED_WDOG_EN.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ     = NumReqDefault,
   parameter int unsigned WDOG_CYCLES = WdogCyclesDefault
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   input  logic                 tx_busy,
   input  logic                 tx_done,
   output logic [1:0]           grant_id,
   output logic                 sched_busy,
   output logic                 wdog_err
);

   sched_state_e   state_q, state_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic [IdW-1:0] grant_q, grant_d;
   logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
   logic           lock_q, lock_d;

   logic [IdW-1:0] arb_ptr, arb_winner;
   logic           arb_any;
   logic [7:0]     sel_data;
   logic           sel_last;
   logic           wdog_hit, wdog_abort;

   // While locked the search is pinned to the current owner.
   assign arb_ptr = lock_q ? grant_q : rr_ptr_q;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .valid_i     (req_valid),
      .ptr_i       (arb_ptr),
      .lock_i      (lock_q),
      .winner_o    (arb_winner),
      .any_valid_o (arb_any)
   );

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (IdW'(i) == arb_winner) begin
            sel_data = req_data[8*i +: 8];
            sel_last = req_last[i];
         end
      end
   end

`ifdef UART_SCHED_WDOG_EN
   localparam int unsigned CntW = $clog2(WDOG_CYCLES + 1);

   logic [CntW-1:0] wdog_cnt_q, wdog_cnt_d;

   always_comb begin
      wdog_cnt_d = wdog_cnt_q;
      if (state_q == StLoad) begin
         wdog_cnt_d = '0;
      end else if ((state_q == StWaitBusy || state_q == StWaitDone) &&
                   wdog_cnt_q < CntW'(WDOG_CYCLES)) begin
         wdog_cnt_d = wdog_cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) wdog_cnt_q <= '0;
      else     wdog_cnt_q <= wdog_cnt_d;
   end

   assign wdog_hit = (state_q == StWaitBusy || state_q == StWaitDone) &&
                     (wdog_cnt_q >= CntW'(WDOG_CYCLES - 1));
`else
   assign wdog_hit = 1'b0;
`endif

   // A completion arriving on the deadline cycle still counts as success.
   assign wdog_abort = wdog_hit && !tx_done;
   assign wdog_err   = wdog_abort && !rst;

   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      lock_d    = lock_q;
      req_ready = '0;
      tx_start  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (|req_valid) state_d = StArb;
         end
         StArb: begin
            if (arb_any) begin
               for (int unsigned i = 0; i < NUM_REQ; i++) begin
                  if (IdW'(i) == arb_winner) req_ready[i] = 1'b1;
               end
               tx_data_d = sel_data;
               grant_d   = arb_winner;
               rr_ptr_d  = next_id(arb_winner, NUM_REQ);
               lock_d    = !sel_last;
               state_d   = StLoad;
            end else if (!lock_q) begin
               state_d = StIdle;
            end
         end
         StLoad: begin
            tx_start = 1'b1;
            state_d  = StWaitBusy;
         end
         StWaitBusy: begin
            if (tx_busy || tx_done) state_d = StWaitDone;
         end
         StWaitDone: begin
            if (tx_done) state_d = StGap;
         end
         StGap: begin
            if (!tx_done) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (wdog_abort) begin
         state_d  = StGap;
         lock_d   = 1'b0;
         rr_ptr_d = next_id(grant_q, NUM_REQ);
      end

      // Nothing is offered or launched while reset is asserted.
      if (rst) begin
         req_ready = '0;
         tx_start  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         tx_data_q <= '0;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         lock_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         lock_q    <= lock_d;
      end
   end

   assign tx_data    = tx_data_q;
   assign grant_id   = grant_q;
   assign sched_busy = (state_q != StIdle) && !rst;

endmodule
